// File: rtl/c499_sec_pkg.sv
// rtl/c499_sec_pkg.sv - shared constants and parity-check helpers for the c499-style SEC decoder
package c499_sec_pkg;

    localparam int DW = 32;
    localparam int CW = 8;

    // Column for data bit i = 8g + k: one-hot group in [7:4], k+1 in [3:0].
    function automatic logic [CW-1:0] col_h(input int i);
        logic [CW-1:0] h;
        logic [4:0]    idx;
        idx     = i[4:0];
        h[7:4]  = 4'b0001 << idx[4:3];
        h[3:0]  = {1'b0, idx[2:0]} + 4'd1;
        return h;
    endfunction

    function automatic logic [CW-1:0] syndrome(input logic [DW-1:0] data,
                                               input logic [CW-1:0] check);
        logic [CW-1:0] s;
        s = check;
        for (int i = 0; i < DW; i++) begin
            if (data[i]) begin
                s = s ^ col_h(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/c499_sec_syndrome.sv
// rtl/c499_sec_syndrome.sv - combinational 32+8 to 8 syndrome XOR tree
module c499_sec_syndrome
    import c499_sec_pkg::*;
(
    input  logic [DW-1:0] data,
    input  logic [CW-1:0] check,
    output logic [CW-1:0] syn
);

    // Each syndrome bit is the check bit XORed with every data bit whose column has that row set.
    always_comb begin
        syn = '0;
        for (int j = 0; j < CW; j++) begin
            logic acc;
            acc = check[j];
            for (int i = 0; i < DW; i++) begin
                logic [CW-1:0] h;
                h   = col_h(i);
                acc = acc ^ (data[i] & h[j]);
            end
            syn[j] = acc;
        end
    end

endmodule

// File: rtl/c499_sec.sv
// rtl/c499_sec.sv - 32-bit single-error-correcting decoder with registered output
module c499_sec
    import c499_sec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic [CW-1:0] check_in,
    input  logic          corr_en,
    output logic [DW-1:0] data_out
);

    logic [CW-1:0] syn;
    logic [DW-1:0] flip;
    logic [DW-1:0] corrected;

    c499_sec_syndrome u_syndrome (
        .data  (data_in),
        .check (check_in),
        .syn   (syn)
    );

    // Zero and unit-vector syndromes never match a column, so they leave data untouched.
    always_comb begin
        flip = '0;
        for (int i = 0; i < DW; i++) begin
            flip[i] = corr_en & (syn == col_h(i));
        end
        corrected = data_in ^ flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= corrected;
        end
    end

endmodule

// File: tb/tb_c499_sec.sv
// tb/tb_c499_sec.sv - self-checking bench for c499_sec against an arithmetic SEC model
module tb_c499_sec;
    import c499_sec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [7:0]  check_in = 8'h0;
    logic        corr_en = 1'b0;
    logic [31:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_exp = 32'h0;
    logic        model_valid = 1'b0;

    c499_sec dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .check_in (check_in),
        .corr_en  (corr_en),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_col(input int i);
        int v;
        v = (16 << (i / 8)) | ((i % 8) + 1);
        return v[7:0];
    endfunction

    function automatic logic [31:0] ref_decode(input logic [31:0] d, input logic [7:0] c,
                                               input logic e);
        logic [7:0]  s;
        logic [31:0] r;
        s = c;
        for (int i = 0; i < 32; i++) if (d[i]) s = s ^ ref_col(i);
        r = d;
        if (e) begin
            for (int i = 0; i < 32; i++) if (ref_col(i) == s) r[i] = ~r[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_exp   <= ref_decode(data_in, check_in, corr_en);
        model_valid <= rst_n;
    end

    always @(negedge clk) begin
        if (!rst_n) check("reset_hold", data_out, 32'h0);
        else if (model_valid) check("model", data_out, model_exp);
    end

    task automatic vec(input string name, input logic [31:0] d, input logic [7:0] c,
                       input logic e, input logic [31:0] exp);
        data_in  = d;
        check_in = c;
        corr_en  = e;
        @(posedge clk);
        @(negedge clk);
        check(name, data_out, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c;

        check("model_pin_bit9", ref_decode(32'h00000201, 8'h11, 1'b1), 32'h00000001);
        check("model_pin_bit31", ref_decode(32'h80000000, 8'h00, 1'b1), 32'h00000000);
        check("model_pin_off", ref_decode(32'h00000201, 8'h11, 1'b0), 32'h00000201);

        data_in  = 32'hDEADBEEF;
        check_in = 8'h5A;
        corr_en  = 1'b1;
        #2;
        check("reset_immediate", data_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("reset_through_edge", data_out, 32'h0);
        rst_n = 1'b1;

        vec("post_reset", 32'h00000001, 8'h11, 1'b1, 32'h00000001);
        vec("clean_zero", 32'h00000000, 8'h00, 1'b1, 32'h00000000);
        vec("clean_ones", 32'hFFFFFFFF, 8'h00, 1'b1, 32'hFFFFFFFF);
        vec("err_bit9", 32'h00000201, 8'h11, 1'b1, 32'h00000001);
        vec("err_bit31", 32'h80000000, 8'h00, 1'b1, 32'h00000000);
        vec("check_err", 32'h00000000, 8'h04, 1'b1, 32'h00000000);
        vec("enable_off", 32'h00000201, 8'h11, 1'b0, 32'h00000201);

        // Asynchronous reset asserted mid-cycle must clear the output without a clock edge.
        vec("pre_async", 32'hA5A5A5A5, syndrome(32'hA5A5A5A5, 8'h00), 1'b1, 32'hA5A5A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("after_async", 32'h12345678, syndrome(32'h12345678, 8'h00), 1'b1, 32'h12345678);

        for (int b = 0; b < 32; b++) begin
            d = $urandom;
            c = syndrome(d, 8'h00);
            vec($sformatf("single_err_%0d", b), d ^ (32'h1 << b), c, 1'b1, d);
        end

        for (int n = 0; n < 200; n++) begin
            data_in  = $urandom;
            check_in = 8'($urandom);
            corr_en  = 1'($urandom);
            @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
